// File: rtl/muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// muldiv_ctrl
//   Iterative multiply/divide unit and its sequencing FSM. It owns the
//   architectural HI/LO registers. It is started by MULT/MULTU/DIV/DIVU in EX
//   and stalls ID while busy whenever ID needs HI/LO or the unit itself.
//
//   FSM: IDLE -> SETUP -> ITER (WIDTH cycles) -> FIX -> IDLE
//   Fixed latency: start edge N -> hi/lo/done valid after edge N+WIDTH+2.
//
// Configuration macro:
//   MULDIV_EARLY_EN - multiply leaves ITER as soon as the remaining multiplier
//                     bits are zero. The accumulator is shifted by the
//                     remaining count in a single cycle. Divide is unaffected.
//
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   EX_start, EX_op     start strobe; op 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   EX_a, EX_b          rs / rt operands (after forwarding)
//   EX_mthi, EX_mtlo    direct HI/LO writes from EX_wdata (IDLE only)
//   ID_hilo_use         ID holds an instruction that touches HI/LO or the unit
//   stall               busy & ID_hilo_use (combinational)
//   busy                an operation is in flight
//   done                one-cycle pulse after the HI/LO update edge
//   hi, lo              architectural HI/LO
// ----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             EX_start,
    input  logic [1:0]       EX_op,
    input  logic [WIDTH-1:0] EX_a,
    input  logic [WIDTH-1:0] EX_b,
    input  logic             EX_mthi,
    input  logic             EX_mtlo,
    input  logic [WIDTH-1:0] EX_wdata,
    input  logic             ID_hilo_use,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ITER, FIX} state_t;

    // Operation captured at the start edge; raw operands are kept for the
    // divide-by-zero result and for sign bookkeeping.
    typedef struct packed {
        logic             is_div;
        logic             is_signed;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_req_t;

    state_t             state, state_nxt;
    op_req_t            req;
    logic [WIDTH-1:0]   mcand;     // multiplicand / divisor magnitude
    logic [WIDTH-1:0]   mplier;    // multiplier (shifts right) / dividend->quotient (shifts left)
    logic [2*WIDTH-1:0] acc;       // product accumulator; upper half is the remainder for divide
    logic [CW-1:0]      cnt;
    logic               neg_res;   // product / quotient must be negated
    logic               neg_rem;   // remainder must be negated
    logic               early;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   trial;
    logic               fits;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rmd;

    assign busy  = (state != IDLE);
    assign stall = busy & ID_hilo_use;

    // ------------------------------------------------------------------
    // Datapath combinational helpers
    // ------------------------------------------------------------------
    always_comb begin
        mag_a   = (req.is_signed && req.a[WIDTH-1]) ? -req.a : req.a;
        mag_b   = (req.is_signed && req.b[WIDTH-1]) ? -req.b : req.b;

        // Multiply step: conditional add of the multiplicand into the top half.
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};

        // Restoring divide step: shift the next dividend bit into the remainder.
        // A successful subtraction is always below the divisor, so WIDTH bits hold it.
        rem_sh  = {acc[2*WIDTH-1:WIDTH], mplier[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, mcand});
        trial   = rem_sh[WIDTH-1:0] - mcand;

        prod    = neg_res ? -acc : acc;
        quo     = neg_res ? -mplier : mplier;
        rmd     = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

        early   = 1'b0;
`ifdef MULDIV_EARLY_EN
        early   = (state == ITER) && !req.is_div && (mplier == '0);
`else
`endif
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (EX_start) state_nxt = SETUP;
            SETUP: state_nxt = ITER;
            ITER:  if (early || cnt == CW'(1)) state_nxt = FIX;
            FIX:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and HI/LO
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A start takes priority over a same-cycle MTHI/MTLO.
                    if (EX_start) begin
                        req <= '{is_div: EX_op[1], is_signed: ~EX_op[0], a: EX_a, b: EX_b};
                    end else begin
                        if (EX_mthi) hi <= EX_wdata;
                        if (EX_mtlo) lo <= EX_wdata;
                    end
                end
                SETUP: begin
                    cnt     <= CW'(WIDTH);
                    acc     <= '0;
                    neg_res <= req.is_signed & (req.a[WIDTH-1] ^ req.b[WIDTH-1]);
                    neg_rem <= req.is_signed & req.a[WIDTH-1];
                    if (req.is_div) begin
                        mplier <= mag_a;
                        mcand  <= mag_b;
                    end else begin
                        mplier <= mag_b;
                        mcand  <= mag_a;
                    end
                end
                ITER: begin
                    if (early) begin
                        // Remaining steps would only shift right by one each.
                        acc <= acc >> cnt;
                        cnt <= '0;
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (req.is_div) begin
                            acc[2*WIDTH-1:WIDTH] <= fits ? trial : rem_sh[WIDTH-1:0];
                            mplier               <= {mplier[WIDTH-2:0], fits};
                        end else begin
                            acc    <= {add_sum, acc[WIDTH-1:1]};
                            mplier <= mplier >> 1;
                        end
                    end
                end
                FIX: begin
                    done <= 1'b1;
                    if (req.is_div) begin
                        if (req.b == '0) begin
                            lo <= '1;
                            hi <= req.a;
                        end else begin
                            lo <= quo;
                            hi <= rmd;
                        end
                    end else begin
                        {hi, lo} <= prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_muldiv_ctrl
//   Directed and randomized checks of muldiv_ctrl against an arithmetic
//   reference model (64-bit products, SV / and % for divide).
// ----------------------------------------------------------------------------
module tb_muldiv_ctrl;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          EX_start = 1'b0, EX_mthi = 1'b0, EX_mtlo = 1'b0, ID_hilo_use = 1'b0;
    logic [1:0]    EX_op = 2'd0;
    logic [W-1:0]  EX_a = '0, EX_b = '0, EX_wdata = '0;
    logic          stall, busy, done;
    logic [W-1:0]  hi, lo;

    int            tests = 0;
    int            fails = 0;
    logic [W-1:0]  hi_m = '0, lo_m = '0;

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .EX_start(EX_start), .EX_op(EX_op), .EX_a(EX_a), .EX_b(EX_b),
        .EX_mthi(EX_mthi), .EX_mtlo(EX_mtlo), .EX_wdata(EX_wdata),
        .ID_hilo_use(ID_hilo_use),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {hi, lo} expected from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] r;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            2'd0: r = sa * sb;
            2'd1: r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 0)         r = {a, 32'hFFFF_FFFF};
                else if (op == 2'd2) r = {32'(sa % sb), 32'(sa / sb)};
                else                r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Cycles from the start edge until done is seen.
    function automatic int exp_lat(input logic [1:0] op, input logic [31:0] b);
        int l;
        l = W + 2;
`ifdef MULDIV_EARLY_EN
        begin
            logic [31:0] mag;
            int bl;
            if (!op[1]) begin
                mag = (!op[0] && b[31]) ? -b : b;
                bl = 0;
                for (int i = 0; i < 32; i++) if (mag[i]) bl = i + 1;
                if (3 + bl < l) l = 3 + bl;
            end
        end
`else
        if (op[1]) l = W + 2;
`endif
        return l;
    endfunction

    // Start an op, optionally with a same-edge MTLO and a mid-flight intruding
    // start/MTHI/MTLO at iteration 'intrude'; check timing, hold and result.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic hazard, input logic with_mt,
                          input int intrude);
        logic [63:0] e;
        int n, bad;
        e = model(op, a, b);
        EX_start = 1'b1; EX_op = op; EX_a = a; EX_b = b; ID_hilo_use = hazard;
        EX_mtlo = with_mt; EX_wdata = 32'hA5A5_0001;
        tick();
        EX_start = 1'b0; EX_mtlo = 1'b0;
        chk({tag, " busy"}, busy, 1);
        n = 0; bad = 0;
        while (!done && n < 200) begin
            if (stall !== (busy & hazard) || busy !== 1'b1 || hi !== hi_m || lo !== lo_m) bad++;
            if (n == intrude) begin
                EX_start = 1'b1; EX_op = 2'd3; EX_a = ~a; EX_b = 32'd3;
                EX_mthi = 1'b1; EX_mtlo = 1'b1; EX_wdata = 32'hDEAD_BEEF;
            end else begin
                EX_start = 1'b0; EX_mthi = 1'b0; EX_mtlo = 1'b0;
            end
            tick();
            n++;
        end
        EX_start = 1'b0; EX_mthi = 1'b0; EX_mtlo = 1'b0;
        chk({tag, " latency"}, n, exp_lat(op, b));
        chk({tag, " hold/stall"}, bad, 0);
        chk({tag, " result"}, {hi, lo}, e);
        chk({tag, " idle"}, {busy, stall}, 2'b00);
        hi_m = e[63:32]; lo_m = e[31:0];
        tick();
        chk({tag, " pulse"}, done, 0);
        ID_hilo_use = 1'b0;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        reset_n = 1'b0;
        #12;
        chk("reset state", {busy, done, stall, hi, lo}, '0);
        reset_n = 1'b1;
        tick();

        // 1: signed multiply
        run_op("mult", 2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, -1);
        chk("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // 2: unsigned divide with ID hazard held high
        run_op("divu", 2'd3, 32'd100, 32'd7, 1'b1, 1'b0, -1);
        chk("divu const", {hi, lo}, {32'd2, 32'd14});

        // 3: boundaries
        run_op("div ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
        chk("div ovf const", {hi, lo}, {32'd0, 32'h8000_0000});
        run_op("divu by0", 2'd3, 32'd5, 32'd0, 1'b0, 1'b0, -1);
        chk("divu by0 const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        run_op("div by0 neg", 2'd2, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b0, -1);
        run_op("div signs", 2'd2, 32'hFFFF_FF9C, 32'd7, 1'b1, 1'b0, -1);

        // 4: MTHI while idle, start beats MTLO, intrusion while busy
        EX_mthi = 1'b1; EX_wdata = 32'h0000_1234;
        tick();
        EX_mthi = 1'b0;
        chk("mthi hi", hi, 32'h0000_1234);
        chk("mthi lo", lo, lo_m);
        hi_m = 32'h0000_1234;
        EX_mtlo = 1'b1; EX_wdata = 32'h0BAD_F00D;
        tick();
        EX_mtlo = 1'b0;
        chk("mtlo lo", {hi, lo}, {32'h0000_1234, 32'h0BAD_F00D});
        lo_m = 32'h0BAD_F00D;
        run_op("start+mtlo", 2'd1, 32'd11, 32'd13, 1'b0, 1'b1, -1);
        run_op("intrude", 2'd0, 32'h1234_5678, 32'hF00F_0FF1, 1'b1, 1'b0, 10);

        // 5: reset in the middle of ITER
        EX_start = 1'b1; EX_op = 2'd0; EX_a = 32'h1234_5678; EX_b = 32'h09AB_CDEF;
        tick();
        EX_start = 1'b0;
        repeat (16) tick();
        chk("pre-abort busy", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("abort", {busy, done, stall, hi, lo}, '0);
        hi_m = '0; lo_m = '0;
        #3 reset_n = 1'b1;
        tick();
        run_op("multu 6x7", 2'd1, 32'd6, 32'd7, 1'b0, 1'b0, -1);
        chk("multu 6x7 const", {hi, lo}, 64'd42);

        // 6: small multipliers (early finish when enabled)
        run_op("multu 9x0", 2'd1, 32'd9, 32'd0, 1'b0, 1'b0, -1);
        run_op("multu 9x1", 2'd1, 32'd9, 32'd1, 1'b0, 1'b0, -1);
        run_op("mult neg b", 2'd0, 32'd9, 32'hFFFF_FFFC, 1'b0, 1'b0, -1);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op("random", rop, ra, rb, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
